// File: rtl/common_pkg.sv
// Shared datapath definitions for the NoC stream blocks.
package common_pkg;

    // Default payload width for stream words.
    localparam int unsigned DEFAULT_D_W = 32;

    // Packet-tracking state of stream_demux.
    typedef enum logic {
        IDLE,   // next accepted beat is a packet head
        BUSY    // mid-packet, destination locked
    } stream_demux_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for the 1-to-N stream demultiplexer.
import common_pkg::*;

interface stream_demux_if #(
    parameter int unsigned N = 6,
    parameter int unsigned W = DEFAULT_D_W
);
    localparam int unsigned L = (N > 1) ? $clog2(N) : 1;

    logic [L-1:0]          sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  in_last;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic [N-1:0][W-1:0]   out_data;
    logic [N-1:0]          out_last;
    logic                  err_bad_sel;

    // Producer/consumer side: drives the input stream and the per-port ready.
    modport master (
        output sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_bad_sel
    );

    // Demux side.
    modport slave (
        input  sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, err_bad_sel
    );

endinterface

// File: rtl/experiment_generic_demux6.sv
// Flat-port 6-output stream_demux for FPGA mapping comparison.
import common_pkg::*;

module experiment_generic_demux6 #(
    parameter int unsigned W = DEFAULT_D_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     sel,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    output logic [5:0]     out_valid,
    input  logic [5:0]     out_ready,
    output logic [6*W-1:0] out_data,
    output logic [5:0]     out_last,
    output logic           err_bad_sel
);

    stream_demux_if #(.N(6), .W(W)) bus ();

    assign bus.sel       = sel;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_last   = in_last;
    assign bus.out_ready = out_ready;
    assign in_ready      = bus.in_ready;
    assign out_valid     = bus.out_valid;
    assign out_data      = bus.out_data;
    assign out_last      = bus.out_last;
    assign err_bad_sel   = bus.err_bad_sel;

    stream_demux #(.N(6), .W(W)) u_demux (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

endmodule

// File: rtl/stream_out_slot.sv
// One-entry register slice for a single demux output port.
import common_pkg::*;

module stream_out_slot #(
    parameter int unsigned W = DEFAULT_D_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         last_in,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);

    // Load wins over drain so a full slot with ready high refills every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            last  <= last_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer: destination is taken from sel on the head
// beat and held for the rest of the packet; each port has a one-entry slot.
import common_pkg::*;

module stream_demux #(
    parameter int unsigned N = 6,
    parameter int unsigned W = DEFAULT_D_W
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave io
);

    localparam int unsigned L     = (N > 1) ? $clog2(N) : 1;
    localparam logic [L:0]  N_LIM = (L+1)'(N);

    stream_demux_state_t state, state_nxt;
    logic [L-1:0]        lock_sel;
    logic [L-1:0]        target;
    logic                tgt_ok;
    logic                rdy;
    logic                accept;
    logic [N-1:0]        load;
    logic [N-1:0]        can_load;
    logic [N-1:0]        slot_valid;
    logic [N-1:0]        slot_last;
    logic [N-1:0][W-1:0] slot_data;
    logic                err_q;

    assign can_load = ~slot_valid | io.out_ready;

    // Route selection, input handshake, slot load strobes and next state.
    // A target outside 0..N-1 matches no slot, so rdy stays 1 and the beat is dropped.
    always_comb begin
        state_nxt = state;
        target    = (state == IDLE) ? io.sel : lock_sel;
        tgt_ok    = ({1'b0, target} < N_LIM);
        rdy       = 1'b1;
        load      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (target == L'(k)) begin
                rdy = can_load[k];
            end
        end
        accept = io.in_valid && rdy;
        for (int unsigned k = 0; k < N; k++) begin
            load[k] = accept && (target == L'(k));
        end
        case (state)
            IDLE:    if (accept && !io.in_last) state_nxt = BUSY;
            BUSY:    if (accept &&  io.in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Packet-tracking state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture destination on a multi-beat head; flag heads with an invalid select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sel <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && accept) begin
            if (!io.in_last) begin
                lock_sel <= io.sel;
            end
            if (!tgt_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        stream_out_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .data_in (io.in_data),
            .last_in (io.in_last),
            .ready   (io.out_ready[k]),
            .valid   (slot_valid[k]),
            .data    (slot_data[k]),
            .last    (slot_last[k])
        );
    end

    assign io.in_ready    = rdy;
    assign io.out_valid   = slot_valid;
    assign io.out_data    = slot_data;
    assign io.out_last    = slot_last;
    assign io.err_bad_sel = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux with a per-port scoreboard.
import common_pkg::*;

module tb_stream_demux;

    localparam int unsigned N = 6;
    localparam int unsigned W = DEFAULT_D_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_demux_if #(.N(N), .W(W)) bus ();

    stream_demux #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Expected {last, data} per port, plus the bench's own view of packet state.
    logic [W:0] sb [N][$];
    bit         m_busy;
    logic [2:0] m_lock;
    bit         m_err;

    task automatic clear_model();
        for (int k = 0; k < N; k++) sb[k].delete();
        m_busy = 0;
        m_lock = '0;
        m_err  = 0;
    endtask

    // One clock: at the falling edge score outputs/handshake, advance the model,
    // then return just after the next rising edge.
    task automatic cycle(output bit acc);
        logic [2:0] t;
        logic [W:0] exp;
        bit         erdy;
        acc = 0;
        @(negedge clk);
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    n_chk++;
                    if (sb[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_spurious port %0d: got %h, expected no beat", k, bus.out_data[k]);
                    end else begin
                        exp = sb[k].pop_front();
                        if ({bus.out_last[k], bus.out_data[k]} !== exp) begin
                            n_fail++;
                            $display("FAIL sb_data port %0d: got last=%0b data=%h, expected last=%0b data=%h",
                                     k, bus.out_last[k], bus.out_data[k], exp[W], exp[W-1:0]);
                        end
                    end
                end
            end
            t    = m_busy ? m_lock : bus.sel;
            erdy = (t >= N) ? 1'b1 : (!bus.out_valid[t] || bus.out_ready[t]);
            n_chk++;
            if (bus.in_ready !== erdy) begin
                n_fail++;
                $display("FAIL in_ready: got %b, expected %b (target %0d)", bus.in_ready, erdy, t);
            end
            n_chk++;
            if (bus.err_bad_sel !== m_err) begin
                n_fail++;
                $display("FAIL err_bad_sel: got %b, expected %b", bus.err_bad_sel, m_err);
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                if (t < N) sb[t].push_back({bus.in_last, bus.in_data});
                if (!m_busy && t >= N) m_err = 1;
                if (!m_busy && !bus.in_last) begin
                    m_busy = 1;
                    m_lock = bus.sel;
                end else if (m_busy && bus.in_last) begin
                    m_busy = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; cyc = cycles it took.
    task automatic send(input logic [2:0] s, input logic [W-1:0] d, input bit l, output int cyc);
        bit acc;
        bus.sel      = s;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        cyc = 0;
        do begin
            cycle(acc);
            cyc++;
        end while (!acc && cyc < 40);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: beat sel=%0d data=%h not accepted in %0d cycles", s, d, cyc);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.in_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = '1;
        clear_model();
        #12;
        n_chk++;
        if (bus.out_valid !== 6'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 000000", bus.out_valid); end
        n_chk++;
        if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0", bus.out_data); end
        n_chk++;
        if (bus.out_last !== 6'b0) begin n_fail++; $display("FAIL reset_out_last: got %b, expected 000000", bus.out_last); end
        n_chk++;
        if (bus.err_bad_sel !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", bus.err_bad_sel); end
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        int cyc;
        for (int k = 0; k < N; k++) begin
            send(3'(k), W'(32'hA0 + k), 1'b1, cyc);
            n_chk++;
            if (cyc != 1) begin n_fail++; $display("FAIL single_stall port %0d: took %0d cycles, expected 1", k, cyc); end
            n_chk++;
            if (bus.out_valid !== (6'b1 << k)) begin
                n_fail++; $display("FAIL single_valid port %0d: got %b, expected %b", k, bus.out_valid, 6'b1 << k);
            end
            n_chk++;
            if (bus.out_data[k] !== W'(32'hA0 + k)) begin
                n_fail++; $display("FAIL single_data port %0d: got %h, expected %h", k, bus.out_data[k], 32'hA0 + k);
            end
        end
        idle(2);
        n_chk++;
        if (bus.err_bad_sel !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, expected 0", bus.err_bad_sel); end
    endtask

    task automatic test_packet_lock();
        int cyc;
        send(3'd2, W'(32'h10), 1'b0, cyc);
        n_chk++;
        if (bus.out_valid !== 6'b000100) begin n_fail++; $display("FAIL lock_head: got %b, expected 000100", bus.out_valid); end
        for (int i = 1; i <= 3; i++) begin
            send(3'd4, W'(32'h10 + i), (i == 3), cyc);
            n_chk++;
            if (bus.out_valid !== 6'b000100 || bus.out_data[2] !== W'(32'h10 + i)) begin
                n_fail++;
                $display("FAIL lock_body beat %0d: got valid=%b data2=%h, expected 000100 / %h",
                         i, bus.out_valid, bus.out_data[2], 32'h10 + i);
            end
        end
        idle(1);
        send(3'd4, W'(32'h14), 1'b1, cyc);
        n_chk++;
        if (bus.out_valid !== 6'b010000 || bus.out_data[4] !== W'(32'h14)) begin
            n_fail++;
            $display("FAIL lock_release: got valid=%b data4=%h, expected 010000 / 14", bus.out_valid, bus.out_data[4]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit acc;
        bus.out_ready = 6'b110101;
        send(3'd3, W'(32'h30), 1'b1, cyc);
        send(3'd1, W'(32'h40), 1'b0, cyc);
        n_chk++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL bp_fill: got valid=%b, expected ports 1 and 3 set", bus.out_valid);
        end
        bus.sel     = 3'd1;
        bus.in_data = W'(32'h41);
        bus.in_last = 1'b0;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got in_ready=%b, expected 0", bus.in_ready); end
        cycle(acc);
        bus.out_ready[3] = 1'b1;
        cycle(acc);
        n_chk++;
        if (acc || bus.out_valid[3] !== 1'b0) begin
            n_fail++; $display("FAIL bp_side_drain: got acc=%b valid3=%b, expected 0/0", acc, bus.out_valid[3]);
        end
        cycle(acc);
        n_chk++;
        if (acc) begin n_fail++; $display("FAIL bp_hold: got accept=1, expected 0"); end
        bus.out_ready[1] = 1'b1;
        for (int i = 1; i < 8; i++) begin
            send(3'd1, W'(32'h40 + i), (i == 7), cyc);
            n_chk++;
            if (cyc != 1 || bus.out_valid[1] !== 1'b1 || bus.out_data[1] !== W'(32'h40 + i)) begin
                n_fail++;
                $display("FAIL bp_refill beat %0d: got cycles=%0d valid1=%b data1=%h, expected 1/1/%h",
                         i, cyc, bus.out_valid[1], bus.out_data[1], 32'h40 + i);
            end
        end
        idle(3);
    endtask

    task automatic test_bad_sel();
        int cyc;
        logic [W-1:0] pay [3];
        logic [2:0]   psel [3];
        pay[0] = W'(32'h60); pay[1] = W'(32'h61); pay[2] = W'(32'h62);
        psel[0] = 3'd6;      psel[1] = 3'd0;      psel[2] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            send(psel[i], pay[i], (i == 2), cyc);
            n_chk++;
            if (cyc != 1 || bus.out_valid !== 6'b0 || bus.err_bad_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_sel beat %0d: got cycles=%0d valid=%b err=%b, expected 1/000000/1",
                         i, cyc, bus.out_valid, bus.err_bad_sel);
            end
        end
        send(3'd0, W'(32'h70), 1'b1, cyc);
        n_chk++;
        if (bus.out_valid !== 6'b000001 || bus.out_data[0] !== W'(32'h70) || bus.err_bad_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_sel_after: got valid=%b data0=%h err=%b, expected 000001/70/1",
                     bus.out_valid, bus.out_data[0], bus.err_bad_sel);
        end
        idle(2);
    endtask

    task automatic test_mid_reset();
        int cyc;
        send(3'd5, W'(32'h50), 1'b0, cyc);
        n_chk++;
        if (bus.out_valid !== 6'b100000) begin n_fail++; $display("FAIL rst_head: got %b, expected 100000", bus.out_valid); end
        bus.sel     = 3'd5;
        bus.in_data = W'(32'h51);
        bus.in_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.out_valid !== 6'b0 || bus.out_data !== '0 || bus.out_last !== 6'b0 || bus.err_bad_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b last=%b err=%b data_nonzero=%b, expected all clear",
                     bus.out_valid, bus.out_last, bus.err_bad_sel, (bus.out_data != '0));
        end
        clear_model();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(3'd1, W'(32'h90), 1'b1, cyc);
        n_chk++;
        if (bus.out_valid !== 6'b000010 || bus.out_data[1] !== W'(32'h90)) begin
            n_fail++;
            $display("FAIL rst_after: got valid=%b data1=%h, expected 000010/90", bus.out_valid, bus.out_data[1]);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_chk++;
            if (bus.out_valid[5] !== 1'b0) begin n_fail++; $display("FAIL rst_port5: got valid5=%b, expected 0", bus.out_valid[5]); end
        end
    endtask

    task automatic test_soak();
        bit acc;
        bit pending = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!pending) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.sel      = 3'($urandom_range(0, 7));
                bus.in_data  = W'($urandom);
                bus.in_last  = ($urandom_range(0, 3) == 0);
            end
            bus.out_ready = 6'($urandom);
            cycle(acc);
            pending = bus.in_valid && !acc;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = '1;
        idle(5);
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (sb[k].size() != 0) begin
                n_fail++; $display("FAIL soak_loss port %0d: %0d beats never delivered, expected 0", k, sb[k].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_back_to_back();
        test_bad_sel();
        test_mid_reset();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-N demultiplexer for the NoC datapath. It steers a valid/ready input stream to one of N output ports, using select lines `sel` captured on the first beat of each packet.
- Each output has a registered one-entry slot, so the block also acts as a pipeline stage.
- It is the reader-side counterpart of the generic N-input `mux`, used where a shared link fans back out to N consumers.
- A 6-output configuration is the primary FPGA mapping target.

Parameters:
- N, 6, number of output ports.
- W, DEFAULT_D_W (common_pkg), width of each data word.
- L, $clog2(N), width of the select field; derived, not overridable.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- sel  input  L  destination port, sampled only on the first beat of a packet.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  W  input beat payload.
- in_last  input  1  final beat of packet.
- out_valid  output  N  per-port slot occupied.
- out_ready  input  N  per-port consumer ready.
- out_data  output  N x W  per-port payload.
- out_last  output  N  per-port last flag.
- err_bad_sel  output  1  sticky: a packet head arrived with sel >= N.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All flops clear on rst_n low without waiting for clk.
- Reset values: out_valid=0, out_data=0, out_last=0, err_bad_sel=0, FSM=IDLE, locked select=0.
- FSM states:
  - IDLE (next beat is a packet head): target = sel.
  - BUSY (mid-packet): target = locked select.
- FSM transitions:
  - IDLE -> BUSY on an accepted beat with in_last=0; the current sel is captured into the locked select.
  - BUSY -> IDLE on an accepted beat with in_last=1.
  - A single-beat packet (head with in_last=1) leaves the FSM in IDLE.
  - sel is ignored while BUSY.
- Slot k can load when !out_valid[k] || out_ready[k].
- in_ready = (target < N) ? slot[target] can load : 1.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to any output.
- On an accepted beat to slot k: out_data[k] <= in_data, out_last[k] <= in_last, out_valid[k] <= 1.
  - Latency is exactly 1 cycle from acceptance to out_valid.
- When out_valid[k] && out_ready[k] and no load to k: out_valid[k] <= 0. out_data[k] and out_last[k] hold their last values.
- Full-throughput refill: if slot k is full, out_ready[k]=1, and a new beat targets k in the same cycle, the slot loads the new beat and out_valid[k] stays 1. This sustains 1 beat/cycle.
- Non-target slots drain independently while the input is stalled on a full target.
- Invalid select (sel >= N at head, N not a power of two):
  - The entire packet is accepted (in_ready=1) and dropped.
  - The FSM still tracks in_last; the locked select holds the bad value until the packet ends.
  - err_bad_sel <= 1 on the head beat and stays set until reset.
- At most one slot loads per cycle. Beats of one packet never interleave with another packet.
- Reset mid-packet: all slots are emptied, the FSM returns to IDLE, and the partial packet is lost. The next accepted beat after reset is treated as a head.
- A change of sel while BUSY has no effect. A change of sel while in_valid && !in_ready in IDLE retargets the head (the upstream protocol forbids this; it is not checked).

Decomposition:
- common_pkg gets a `stream_demux_state_t` enum {IDLE, BUSY}; DEFAULT_D_W is reused from there.
- One sub-module, `stream_out_slot`: a one-entry register slice with ports clk, rst_n, load, data_in/last_in, ready, valid/data/last. It is instantiated N times via generate.
- An `experiment_generic_demux6` wrapper with N=6 is added for mapping comparison.

Test Plan:
- Single-beat packets to each port: sel=0..5, in_data=0xA0+k, in_last=1, out_ready all 1. Each out_valid[k] pulses 1 cycle later with out_data[k]=0xA0+k, and err_bad_sel stays 0.
- Packet lock: head with sel=2 and in_last=0, then 3 beats with sel toggled to 4 and the final beat in_last=1. All 4 beats appear only on port 2, port 4 never goes valid, and the FSM is back in IDLE afterwards.
- Back-pressure and refill:
  - Stream 8 beats to port 1 with out_ready[1] held 0. After the first beat, in_ready=0.
  - Raise out_ready[1]. The remaining beats drain at 1 beat/cycle with no bubbles.
  - Meanwhile, a slot full on port 3 drains when out_ready[3]=1 while the input is stalled.
- Bad select: head with sel=6, a 3-beat packet. in_ready stays 1, no out_valid asserts, err_bad_sel rises on the head and stays set. A following packet with sel=0 is delivered normally.
- Mid-packet reset: pull rst_n low asynchronously during beat 2 of a 4-beat packet to port 5.
  - out_valid=0 and out_data=0 immediately.
  - After release, a head with sel=1 routes to port 1 and nothing further reaches port 5.
- Random soak: randomized sel/valid/last/out_ready for 10k cycles against a per-port scoreboard. No loss, no duplication, in-order delivery per port, and packets never interleave.
